// File: rtl/regfile_sb_if.sv
// Bus between the decoder/execute stages and the scoreboarded register file.
// Master drives addresses, write data and reserves; slave returns read data and busy state.
interface regfile_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [1:0]        write_en;
   logic [ADDR_W-1:0] write_addr_0;
   logic [DATA_W-1:0] write_data_0;
   logic [ADDR_W-1:0] write_addr_1;
   logic [DATA_W-1:0] write_data_1;
   logic [ADDR_W-1:0] read_addr_0;
   logic [ADDR_W-1:0] read_addr_1;
   logic [DATA_W-1:0] read_data_0;
   logic [DATA_W-1:0] read_data_1;
   logic              read_busy_0;
   logic              read_busy_1;
   logic              reserve_en;
   logic [ADDR_W-1:0] reserve_addr;
   logic [DEPTH-1:0]  busy_vec;

   modport master (
      output write_en, write_addr_0, write_data_0, write_addr_1, write_data_1,
      output read_addr_0, read_addr_1, reserve_en, reserve_addr,
      input  read_data_0, read_data_1, read_busy_0, read_busy_1, busy_vec
   );

   modport slave (
      input  write_en, write_addr_0, write_data_0, write_addr_1, write_data_1,
      input  read_addr_0, read_addr_1, reserve_en, reserve_addr,
      output read_data_0, read_data_1, read_busy_0, read_busy_1, busy_vec
   );
endinterface

// File: rtl/regfile_sb.sv
// Dual-read/dual-write register file with optional zero register, optional
// write-to-read bypass and a per-register busy scoreboard for multi-cycle producers.
module regfile_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   regfile_sb_if.slave rf
);
   localparam int   DEPTH  = 2 ** ADDR_W;
   localparam logic ZR_EN  = (ZERO_REG != 0);
   localparam logic BYP_EN = (BYPASS != 0);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [DEPTH-1:0]  wr0_hit_s;
   logic [DEPTH-1:0]  wr1_hit_s;
   logic [DEPTH-1:0]  rsv_hit_s;

   logic [ADDR_W-1:0] raddr_s [2];
   logic [DATA_W-1:0] rdata_s [2];
   logic              rbusy_s [2];
   logic              byp0_s  [2];
   logic              byp1_s  [2];
   logic              rzero_s [2];

   // Per-register target decode; a hardwired register 0 is never a write or reserve target.
   always_comb begin
      wr0_hit_s = {DEPTH{1'b0}};
      wr1_hit_s = {DEPTH{1'b0}};
      rsv_hit_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         wr0_hit_s[i] = rf.write_en[0] & (rf.write_addr_0 == ADDR_W'(i)) & ~(ZR_EN & (i == 0));
         wr1_hit_s[i] = rf.write_en[1] & (rf.write_addr_1 == ADDR_W'(i)) & ~(ZR_EN & (i == 0));
         rsv_hit_s[i] = rf.reserve_en  & (rf.reserve_addr == ADDR_W'(i)) & ~(ZR_EN & (i == 0));
      end
   end

   // Next state: port 1 beats port 0 on data, a reserve beats a writeback on busy.
   always_comb begin
      busy_d = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = wr1_hit_s[i] ? rf.write_data_1 :
                     (wr0_hit_s[i] ? rf.write_data_0 : regs_q[i]);
         busy_d[i] = rsv_hit_s[i] | (busy_q[i] & ~(wr0_hit_s[i] | wr1_hit_s[i]));
      end
   end

   // Register array and scoreboard state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
         busy_q <= {DEPTH{1'b0}};
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   assign raddr_s[0] = rf.read_addr_0;
   assign raddr_s[1] = rf.read_addr_1;

   // Read ports: forwarded data also means the producer has landed, so busy is hidden.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         byp0_s[k]  = BYP_EN & rf.write_en[0] & (rf.write_addr_0 == raddr_s[k]);
         byp1_s[k]  = BYP_EN & rf.write_en[1] & (rf.write_addr_1 == raddr_s[k]);
         rzero_s[k] = ZR_EN & (raddr_s[k] == {ADDR_W{1'b0}});
         rdata_s[k] = (!rst_n || rzero_s[k]) ? {DATA_W{1'b0}} :
                      byp1_s[k] ? rf.write_data_1 :
                      byp0_s[k] ? rf.write_data_0 : regs_q[raddr_s[k]];
         rbusy_s[k] = (!rst_n || byp0_s[k] || byp1_s[k]) ? 1'b0 : busy_q[raddr_s[k]];
      end
   end

   assign rf.read_data_0 = rdata_s[0];
   assign rf.read_data_1 = rdata_s[1];
   assign rf.read_busy_0 = rbusy_s[0];
   assign rf.read_busy_1 = rbusy_s[1];
   assign rf.busy_vec    = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Drives three configurations (default, no bypass, zero register) with the same
// stimulus and compares every output against an array-based reference model.
module tb_regfile_sb;
   logic        clk;
   logic        rst_n;
   logic [1:0]  we;
   logic [2:0]  wa0, wa1, ra0, ra1, rsa;
   logic [15:0] wd0, wd1;
   logic        rse;

   logic [15:0] rd0_s [3];
   logic [15:0] rd1_s [3];
   logic        rb0_s [3];
   logic        rb1_s [3];
   logic [7:0]  bv_s  [3];

   logic [15:0] mem_m  [3][8];
   logic        busy_m [3][8];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar g;
   for (g = 0; g < 3; g++) begin : g_dut
      regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) bus ();
      assign bus.write_en     = we;
      assign bus.write_addr_0 = wa0;
      assign bus.write_data_0 = wd0;
      assign bus.write_addr_1 = wa1;
      assign bus.write_data_1 = wd1;
      assign bus.read_addr_0  = ra0;
      assign bus.read_addr_1  = ra1;
      assign bus.reserve_en   = rse;
      assign bus.reserve_addr = rsa;
      assign rd0_s[g] = bus.read_data_0;
      assign rd1_s[g] = bus.read_data_1;
      assign rb0_s[g] = bus.read_busy_0;
      assign rb1_s[g] = bus.read_busy_1;
      assign bv_s[g]  = bus.busy_vec;
      regfile_sb #(
         .DATA_W(16), .ADDR_W(3),
         .ZERO_REG((g == 2) ? 1 : 0),
         .BYPASS((g == 1) ? 0 : 1)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .rf(bus)
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // cfg 0: bypass, no zero reg; cfg 1: no bypass; cfg 2: bypass + zero reg
   function automatic logic [15:0] exp_rd(input int c, input logic [2:0] a);
      if (!rst_n) return 16'h0000;
      if (c == 2 && a == 3'd0) return 16'h0000;
      if (c != 1 && we[1] && wa1 == a) return wd1;
      if (c != 1 && we[0] && wa0 == a) return wd0;
      return mem_m[c][a];
   endfunction

   function automatic logic exp_busy(input int c, input logic [2:0] a);
      if (!rst_n) return 1'b0;
      if (c != 1 && ((we[0] && wa0 == a) || (we[1] && wa1 == a))) return 1'b0;
      return busy_m[c][a];
   endfunction

   task automatic model_clear();
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 8; i++) begin
            mem_m[c][i]  = 16'h0000;
            busy_m[c][i] = 1'b0;
         end
   endtask

   task automatic model_upd();
      if (!rst_n) return;
      for (int c = 0; c < 3; c++) begin
         if (we[0] && !(c == 2 && wa0 == 3'd0)) begin
            mem_m[c][wa0]  = wd0;
            busy_m[c][wa0] = 1'b0;
         end
         if (we[1] && !(c == 2 && wa1 == 3'd0)) begin
            mem_m[c][wa1]  = wd1;
            busy_m[c][wa1] = 1'b0;
         end
         if (rse && !(c == 2 && rsa == 3'd0)) busy_m[c][rsa] = 1'b1;
      end
   endtask

   task automatic check_all();
      logic [7:0] eb;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 8; i++) eb[i] = rst_n ? busy_m[c][i] : 1'b0;
         check_eq($sformatf("rd0_c%0d", c), {16'h0, rd0_s[c]}, {16'h0, exp_rd(c, ra0)});
         check_eq($sformatf("rd1_c%0d", c), {16'h0, rd1_s[c]}, {16'h0, exp_rd(c, ra1)});
         check_eq($sformatf("rb0_c%0d", c), {31'h0, rb0_s[c]}, {31'h0, exp_busy(c, ra0)});
         check_eq($sformatf("rb1_c%0d", c), {31'h0, rb1_s[c]}, {31'h0, exp_busy(c, ra1)});
         check_eq($sformatf("bvec_c%0d", c), {24'h0, bv_s[c]}, {24'h0, eb});
      end
   endtask

   task automatic set_in(input logic [1:0] w, input logic [2:0] a0, input logic [15:0] d0,
                         input logic [2:0] a1, input logic [15:0] d1,
                         input logic [2:0] r0, input logic [2:0] r1,
                         input logic rs, input logic [2:0] rsad);
      we = w; wa0 = a0; wd0 = d0; wa1 = a1; wd1 = d1;
      ra0 = r0; ra1 = r1; rse = rs; rsa = rsad;
   endtask

   task automatic settle();
      @(negedge clk);
      check_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_upd();
      #1;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      model_clear();
      check_eq("rst_async_rd0", {16'h0, rd0_s[0]}, 32'h0);
      check_all();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      model_clear();
      set_in(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
      #2;
      check_all();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // reset mid-operation wipes R3
      set_in(2'b01, 3'd3, 16'h1234, 3'd0, 16'h0, 3'd0, 3'd1, 1'b0, 3'd0); settle(); tick();
      set_in(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd3, 3'd1, 1'b1, 3'd4); settle();
      reset_pulse();
      set_in(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd3, 3'd4, 1'b0, 3'd0); settle();
      check_eq("rst_r3", {16'h0, rd0_s[0]}, 32'h0000);
      check_eq("rst_busy4", {24'h0, bv_s[0]}, 32'h0);
      tick();

      // basic write, dual write, collision
      set_in(2'b01, 3'd5, 16'hBEEF, 3'd0, 16'h0, 3'd0, 3'd1, 1'b0, 3'd0); settle(); tick();
      set_in(2'b11, 3'd1, 16'h1111, 3'd2, 16'h2222, 3'd5, 3'd5, 1'b0, 3'd0); settle();
      check_eq("r5_beef", {16'h0, rd0_s[0]}, 32'hBEEF);
      tick();
      set_in(2'b11, 3'd4, 16'hAAAA, 3'd4, 16'h5555, 3'd1, 3'd2, 1'b0, 3'd0); settle();
      check_eq("dual_r1", {16'h0, rd0_s[1]}, 32'h1111);
      check_eq("dual_r2", {16'h0, rd1_s[1]}, 32'h2222);
      tick();
      set_in(2'b01, 3'd6, 16'h0001, 3'd0, 16'h0, 3'd4, 3'd0, 1'b0, 3'd0); settle();
      check_eq("coll_r4", {16'h0, rd0_s[1]}, 32'h5555);
      tick();

      // bypass
      set_in(2'b01, 3'd6, 16'h00FF, 3'd0, 16'h0, 3'd0, 3'd6, 1'b0, 3'd0); settle();
      check_eq("byp_on", {16'h0, rd1_s[0]}, 32'h00FF);
      check_eq("byp_off", {16'h0, rd1_s[1]}, 32'h0001);
      tick();
      set_in(2'b11, 3'd6, 16'h0A0A, 3'd6, 16'h0B0B, 3'd0, 3'd6, 1'b0, 3'd0); settle();
      check_eq("byp_both", {16'h0, rd1_s[0]}, 32'h0B0B);
      check_eq("byp_both_off", {16'h0, rd1_s[1]}, 32'h00FF);
      tick();

      // scoreboard reserve and writeback
      set_in(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd7, 3'd6, 1'b1, 3'd7); settle();
      check_eq("rsv_same_cycle", {31'h0, rb0_s[0]}, 32'h0);
      tick();
      set_in(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd7, 3'd6, 1'b0, 3'd0); settle();
      check_eq("sb_bvec7", {31'h0, bv_s[0][7]}, 32'h1);
      check_eq("sb_rbusy", {31'h0, rb0_s[0]}, 32'h1);
      tick();
      set_in(2'b01, 3'd7, 16'h0042, 3'd0, 16'h0, 3'd7, 3'd6, 1'b0, 3'd0); settle();
      check_eq("sb_wb_busy", {31'h0, rb0_s[0]}, 32'h0);
      check_eq("sb_wb_data", {16'h0, rd0_s[0]}, 32'h0042);
      check_eq("sb_wb_nobyp", {31'h0, rb0_s[1]}, 32'h1);
      tick();
      set_in(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd7, 3'd6, 1'b1, 3'd2); settle();
      check_eq("sb_clear", {31'h0, bv_s[0][7]}, 32'h0);
      tick();

      // reserve + write same register same cycle
      set_in(2'b01, 3'd2, 16'h0033, 3'd0, 16'h0, 3'd2, 3'd7, 1'b1, 3'd2); settle(); tick();
      set_in(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd2, 3'd7, 1'b0, 3'd0); settle();
      check_eq("rw_data", {16'h0, rd0_s[0]}, 32'h0033);
      check_eq("rw_busy", {31'h0, bv_s[0][2]}, 32'h1);
      tick();

      // zero register
      set_in(2'b01, 3'd0, 16'hFFFF, 3'd0, 16'h0, 3'd1, 3'd2, 1'b1, 3'd0); settle(); tick();
      set_in(2'b10, 3'd0, 16'h0, 3'd0, 16'h1357, 3'd0, 3'd0, 1'b0, 3'd0); settle();
      check_eq("zr_byp", {16'h0, rd0_s[2]}, 32'h0);
      check_eq("zr_busy", {31'h0, bv_s[2][0]}, 32'h0);
      check_eq("nzr_byp", {16'h0, rd0_s[0]}, 32'h1357);
      tick();
      set_in(2'b00, 3'd0, 16'h0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0); settle();
      check_eq("zr_read", {16'h0, rd1_s[2]}, 32'h0);
      tick();

      // randomized traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         set_in(2'($urandom_range(0, 3)), 3'($urandom), 16'($urandom),
                3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom),
                1'($urandom_range(0, 2) == 0), 3'($urandom));
         settle();
         if ($urandom_range(0, 199) == 0) reset_pulse();
         else tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 8x16 dual-read/dual-write register file.
- Generalised data width and depth.
- Adds three behaviours:
  - optional hardwired zero register;
  - optional same-cycle write-to-read bypass;
  - per-register busy scoreboard for multi-cycle producers (reserve on issue, clear on writeback).
- Sits between the control unit/decoder (reserve, read addresses) and the execute/writeback stages (write ports).

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers (derived, not a parameter).
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and is never marked busy.
- BYPASS, 1, when 1 a same-cycle write to the addressed register is forwarded to the read port.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- write_en  in  2  bit0 enables write port 0, bit1 enables write port 1 (independent).
- write_addr_0  in  ADDR_W  write port 0 register select.
- write_data_0  in  DATA_W  write port 0 data.
- write_addr_1  in  ADDR_W  write port 1 register select.
- write_data_1  in  DATA_W  write port 1 data.
- read_addr_0  in  ADDR_W  read port 0 register select.
- read_addr_1  in  ADDR_W  read port 1 register select.
- read_data_0  out  DATA_W  read port 0 data (combinational).
- read_data_1  out  DATA_W  read port 1 data (combinational).
- read_busy_0  out  1  addressed register of read port 0 has a pending producer.
- read_busy_1  out  1  addressed register of read port 1 has a pending producer.
- reserve_en  in  1  mark reserve_addr busy at next edge.
- reserve_addr  in  ADDR_W  register being reserved.
- busy_vec  out  DEPTH  registered scoreboard, bit i = register i busy.

Behaviour:
- Reset (rst_n low, async):
  - all registers and busy_vec cleared to 0 immediately;
  - read_data_0/1 and read_busy_0/1 forced to 0 while rst_n is low;
  - writes and reserves ignored while rst_n is low.
- Writes:
  - 1-cycle latency; data is visible in the register array after the rising edge.
  - Both ports may write in the same cycle to different addresses.
  - Same-address collision (both enables set, equal addresses): port 1 wins, port 0 data is discarded.
- Reads:
  - combinational from the array; no added latency.
  - BYPASS=1: if write_en[k] is set and write_addr_k equals read_addr, read_data returns write_data_k in the same cycle. If both write ports match, port 1 data is returned.
  - BYPASS=0: the read returns the old value until the edge.
- Zero register (ZERO_REG=1):
  - address 0 reads 0 on both ports, including the bypass path;
  - writes to address 0 are dropped;
  - reserve of address 0 is dropped;
  - busy_vec[0] stays 0.
- Scoreboard, per register, 2 states (IDLE, BUSY):
  - IDLE -> BUSY on edge with reserve_en=1 and reserve_addr=i.
  - BUSY -> IDLE on edge with any enabled write port addressing i.
  - Reserve and write to the same address in one cycle: reserve wins; the register ends BUSY and the write data is still stored. This models back-to-back ops to the same destination.
  - Reserve of an already BUSY register: stays BUSY (no count, no error).
  - Write to an IDLE register: allowed; busy stays 0.
- read_busy_k:
  - base value is busy_vec[read_addr_k].
  - BYPASS=1: forced 0 when a same-cycle enabled write matches read_addr_k (data is being forwarded).
  - A same-cycle reserve does not affect read_busy (it takes effect next cycle).
- busy_vec is purely registered; no combinational path from inputs.
- Releasing rst_n mid-operation gives the clean reset state; no pending state survives.

Test Plan:
- Reset/basic write-read:
  - Stimulus: assert rst_n=0 mid-simulation after writing R3=0x1234.
  - Required: read_data_0 is 0 immediately; after release, R3 reads 0x0000.
  - Stimulus: write R5=0xBEEF on port 0.
  - Required: read_addr_0=5 gives 0xBEEF next cycle.
- Dual write and collision:
  - Stimulus: port0 R1=0x1111 and port1 R2=0x2222 in the same cycle.
  - Required: both stored.
  - Stimulus: port0 R4=0xAAAA and port1 R4=0x5555 in the same cycle.
  - Required: R4 reads 0x5555.
- Bypass:
  - BYPASS=1, R6 holds 0x0001, write R6=0x00FF with read_addr_1=6 in the same cycle -> read_data_1=0x00FF in that cycle.
  - Same with both ports writing R6 (0x0A0A port 0, 0x0B0B port 1) -> read_data_1=0x0B0B.
  - BYPASS=0 -> read_data_1=0x0001 until the edge.
- Scoreboard:
  - reserve R7 -> busy_vec[7]=1 next cycle, read_busy_0=1 with read_addr_0=7.
  - Write R7=0x0042 -> busy clears after the edge.
  - With BYPASS=1, read_busy_0=0 and read_data_0=0x0042 during the write cycle.
- Reserve/write same cycle:
  - R2 BUSY; write R2=0x0033 plus reserve R2 in one cycle -> R2=0x0033 and busy_vec[2] still 1.
- Zero register:
  - ZERO_REG=1; write R0=0xFFFF and reserve R0 -> R0 reads 0x0000, busy_vec[0]=0, bypass read of addr 0 returns 0.
